// File: rtl/spi_pkg.sv
// Shared types and frame packing for the SPI initiator that drives spi_bridge.
package spi_pkg;

    localparam int FRAME_BITS = 32;
    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 8;
    localparam int RW_BIT     = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRAME,
        ST_GAP,
        ST_WAIT_RDY,
        ST_RDBYTE,
        ST_DONE
    } state_t;

    // Byte 0 carries rw_n in bit 7 and addr[16] in bit 0; reads send a zero data byte.
    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic              rw_n,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        logic [7:0] hdr;
        hdr         = 8'h00;
        hdr[RW_BIT] = rw_n;
        hdr[0]      = addr[ADDR_W-1];
        return {hdr, addr[15:0], (rw_n ? 8'h00 : data)};
    endfunction

endpackage

// File: rtl/spi_shifter.sv
// SCLK divider plus MSB-first shift register, mode 0; bit count is loaded on every start.
module spi_shifter
    import spi_pkg::*;
#(
    parameter int SCLK_HALF = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [5:0]            nbits,
    input  logic [FRAME_BITS-1:0] load_data,
    input  logic                  rx,
    output logic                  sclk,
    output logic                  tx,
    output logic                  last_fall,
    output logic [DATA_W-1:0]     rx_data
);

    localparam logic [15:0] HALF_LAST = 16'(SCLK_HALF - 1);

    logic                  active;
    logic [15:0]           div_cnt;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  edge_due;

    assign tx        = shreg[FRAME_BITS-1];
    assign edge_due  = active && (div_cnt == HALF_LAST);
    assign last_fall = edge_due && sclk && (bit_cnt == 6'd1);

    // Rise samples MISO; fall advances MOSI, so the first bit is set up a half period early.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            sclk    <= 1'b0;
            div_cnt <= 16'd0;
            bit_cnt <= 6'd0;
            shreg   <= '0;
            rx_data <= '0;
        end else if (start) begin
            active  <= 1'b1;
            sclk    <= 1'b0;
            div_cnt <= 16'd0;
            bit_cnt <= nbits;
            shreg   <= load_data;
        end else if (active) begin
            if (edge_due) begin
                div_cnt <= 16'd0;
                if (!sclk) begin
                    sclk    <= 1'b1;
                    rx_data <= {rx_data[DATA_W-2:0], rx};
                end else begin
                    sclk    <= 1'b0;
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt - 6'd1;
                    if (bit_cnt == 6'd1) begin
                        active <= 1'b0;
                    end
                end
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/spi_initiator.sv
// Parallel command to spi_bridge SPI frame, waits for bridge ready, returns read data.
// Optional ready timeout enabled by defining SPI_INITIATOR_TIMEOUT_EN.
module spi_initiator
    import spi_pkg::*;
#(
    parameter int SCLK_HALF     = 4,
    parameter int CS_GAP        = 4,
    parameter int READY_TIMEOUT = 1024
) (
    input  logic              clk_sys_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_rw_ni,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_timeout_o,
    output logic              spi_sclk_o,
    output logic              spi_cs_no,
    output logic              spi_tx_o,
    input  logic              spi_rx_i,
    input  logic              spi_ready_ni
);

    localparam logic [15:0] GAP_LAST = 16'((CS_GAP > 0) ? (CS_GAP - 1) : 0);

    state_t                state;
    logic                  rdy_meta;
    logic                  rdy_sync;
    logic                  rdy_seen_high;
    logic                  rw_q;
    logic                  cs_n;
    logic [15:0]           gap_cnt;
    logic [DATA_W-1:0]     rsp_data_q;
    logic                  rsp_timeout_q;

    logic                  accept;
    logic                  rdy_ok;
    logic                  rd_start;
    logic                  timeout_hit;
    logic                  sh_start;
    logic                  sh_last;
    logic [5:0]            sh_nbits;
    logic [FRAME_BITS-1:0] sh_load;
    logic [DATA_W-1:0]     sh_rx;

    assign cmd_ready_o   = (state == ST_IDLE);
    assign rsp_valid_o   = (state == ST_DONE);
    assign rsp_data_o    = rsp_data_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign spi_cs_no     = cs_n;

    // Ready only counts once it has been seen high after cs rose, so a stale low is ignored.
    always_comb begin
        accept   = cmd_valid_i && (state == ST_IDLE);
        rdy_ok   = rdy_seen_high && !rdy_sync;
        rd_start = (state == ST_WAIT_RDY) && rdy_ok && rw_q;
        sh_start = accept || rd_start;
        sh_nbits = accept ? 6'(FRAME_BITS) : 6'(DATA_W);
        sh_load  = accept ? pack_frame(cmd_rw_ni, cmd_addr_i, cmd_data_i) : '0;
    end

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            rdy_meta <= 1'b1;
            rdy_sync <= 1'b1;
        end else begin
            rdy_meta <= spi_ready_ni;
            rdy_sync <= rdy_meta;
        end
    end

`ifdef SPI_INITIATOR_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(READY_TIMEOUT - 1);

    logic [15:0] tmo_cnt;

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            tmo_cnt <= 16'd0;
        end else if (state != ST_WAIT_RDY) begin
            tmo_cnt <= 16'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign timeout_hit = (state == ST_WAIT_RDY) && (tmo_cnt == TIMEOUT_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = ^16'(READY_TIMEOUT);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= ST_IDLE;
            cs_n          <= 1'b1;
            rw_q          <= 1'b0;
            gap_cnt       <= 16'd0;
            rdy_seen_high <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rw_q  <= cmd_rw_ni;
                        cs_n  <= 1'b0;
                        state <= ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    if (sh_last) begin
                        cs_n          <= 1'b1;
                        gap_cnt       <= 16'd0;
                        rdy_seen_high <= 1'b0;
                        state         <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (rdy_sync) begin
                        rdy_seen_high <= 1'b1;
                    end
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_WAIT_RDY;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                ST_WAIT_RDY: begin
                    if (rdy_sync) begin
                        rdy_seen_high <= 1'b1;
                    end
                    if (rdy_ok) begin
                        if (rw_q) begin
                            cs_n  <= 1'b0;
                            state <= ST_RDBYTE;
                        end else begin
                            rsp_data_q    <= '0;
                            rsp_timeout_q <= 1'b0;
                            state         <= ST_DONE;
                        end
                    end else if (timeout_hit) begin
                        rsp_data_q    <= '0;
                        rsp_timeout_q <= 1'b1;
                        state         <= ST_DONE;
                    end
                end
                ST_RDBYTE: begin
                    if (sh_last) begin
                        cs_n          <= 1'b1;
                        rsp_data_q    <= sh_rx;
                        rsp_timeout_q <= 1'b0;
                        state         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    spi_shifter #(
        .SCLK_HALF (SCLK_HALF)
    ) u_shifter (
        .clk       (clk_sys_i),
        .rst       (reset_i),
        .start     (sh_start),
        .nbits     (sh_nbits),
        .load_data (sh_load),
        .rx        (spi_rx_i),
        .sclk      (spi_sclk_o),
        .tx        (spi_tx_o),
        .last_fall (sh_last),
        .rx_data   (sh_rx)
    );

endmodule

// File: tb/tb_spi_initiator.sv
// Directed bench for spi_initiator with a cycle-level spi_bridge stand-in.
module tb_spi_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_rw = 1'b0;
    logic [16:0] cmd_addr = 17'h0;
    logic [7:0]  cmd_data = 8'h0;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_timeout;
    logic        sclk;
    logic        cs_n;
    logic        tx;
    logic        rx;
    logic        ready_n = 1'b1;
    logic [7:0]  miso_byte = 8'h00;

    int n_checks = 0;
    int n_fail = 0;

    spi_initiator #(
        .SCLK_HALF     (2),
        .CS_GAP        (4),
        .READY_TIMEOUT (100)
    ) dut (
        .clk_sys_i     (clk),
        .reset_i       (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_rw_ni     (cmd_rw),
        .cmd_addr_i    (cmd_addr),
        .cmd_data_i    (cmd_data),
        .rsp_valid_o   (rsp_valid),
        .rsp_data_o    (rsp_data),
        .rsp_timeout_o (rsp_timeout),
        .spi_sclk_o    (sclk),
        .spi_cs_no     (cs_n),
        .spi_tx_o      (tx),
        .spi_rx_i      (rx),
        .spi_ready_ni  (ready_n)
    );

    initial forever #5 clk = ~clk;

    // Bus monitor: records each cs-low window, SCLK period and first-bit setup.
    int          cyc = 0;
    int          win_rises = 0;
    int          win_count = 0;
    int          cs_fall_cyc = 0;
    int          cs_rise_cyc = 0;
    int          last_rise_cyc = 0;
    int          gap_last = 0;
    int          per_min = 1000;
    int          per_max = 0;
    int          setup_min = 1000;
    int          setup_max = 0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic [31:0] shift_cap = 32'h0;
    int          win_bits [16];
    logic [31:0] win_data [16];

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_cs   <= cs_n;
        prev_sclk <= sclk;
        if (prev_cs && !cs_n) begin
            cs_fall_cyc <= cyc;
            gap_last    <= cyc - cs_rise_cyc;
            win_rises   <= 0;
        end
        if (!prev_cs && cs_n) begin
            win_bits[win_count % 16] <= win_rises;
            win_data[win_count % 16] <= shift_cap;
            win_count                <= win_count + 1;
            cs_rise_cyc              <= cyc;
        end
        if (!prev_sclk && sclk && !cs_n) begin
            shift_cap     <= {shift_cap[30:0], tx};
            win_rises     <= win_rises + 1;
            last_rise_cyc <= cyc;
            if (win_rises == 0) begin
                if (cyc - cs_fall_cyc < setup_min) setup_min <= cyc - cs_fall_cyc;
                if (cyc - cs_fall_cyc > setup_max) setup_max <= cyc - cs_fall_cyc;
            end else begin
                if (cyc - last_rise_cyc < per_min) per_min <= cyc - last_rise_cyc;
                if (cyc - last_rise_cyc > per_max) per_max <= cyc - last_rise_cyc;
            end
        end
    end

    assign rx = (win_rises < 8) ? miso_byte[3'(7 - win_rises)] : 1'b0;

    typedef struct {
        logic        rw;
        logic [16:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  miso;
        logic [31:0] frame;
        logic [7:0]  rsp;
        int          delay;
        int          lat;
        logic        poke;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic wait_win(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (win_count != base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rsp(input int budget, output bit ok, output int at_cyc);
        ok     = 1'b0;
        at_cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                ok     = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic issue(input logic rw, input logic [16:0] addr, input logic [7:0] data);
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = 17'h0;
        cmd_data  = 8'h0;
    endtask

    task automatic run_vec(input vec_t v);
        int base;
        int rdy_cyc;
        int got_cyc;
        bit ok;
        check("idle_before", 32'(cmd_ready), 32'd1);
        base      = win_count;
        miso_byte = v.miso;
        issue(v.rw, v.addr, v.wdata);
        check("busy_after_accept", 32'(cmd_ready), 32'd0);
        if (v.poke) begin
            repeat (20) @(posedge clk);
            #1;
            cmd_valid = 1'b1;
            cmd_rw    = 1'b1;
            cmd_addr  = 17'h00001;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            cmd_addr  = 17'h0;
        end
        wait_win(base, ok);
        check("frame_end_seen", 32'(ok), 32'd1);
        if (!ok) return;
        if (v.delay > 0) begin
            repeat (v.delay) @(posedge clk);
            #1;
        end
        ready_n = 1'b0;
        rdy_cyc = cyc;
        wait_rsp(400, ok, got_cyc);
        check("rsp_seen", 32'(ok), 32'd1);
        if (ok) begin
            check("rsp_latency", 32'(got_cyc - rdy_cyc), 32'(v.lat));
            check("rsp_data", 32'(rsp_data), 32'(v.rsp));
            check("rsp_timeout", 32'(rsp_timeout), 32'd0);
            check("ready_low_in_pulse", 32'(cmd_ready), 32'd0);
            @(posedge clk);
            #1;
            check("rsp_pulse_1cyc", 32'(rsp_valid), 32'd0);
            check("ready_after_pulse", 32'(cmd_ready), 32'd1);
        end
        ready_n = 1'b1;
        check("frame_bits", 32'(win_bits[base % 16]), 32'd32);
        check("frame_mosi", win_data[base % 16], v.frame);
        if (v.rw) begin
            check("windows_read", 32'(win_count - base), 32'd2);
            check("rdbyte_bits", 32'(win_bits[(base + 1) % 16]), 32'd8);
            check("rdbyte_mosi_zero", 32'(win_data[(base + 1) % 16][7:0]), 32'd0);
            check("rd_cs_gap_min", 32'(gap_last >= 4), 32'd1);
        end else begin
            check("windows_write", 32'(win_count - base), 32'd1);
        end
    endtask

    initial begin
        int  base;
        int  rdy_cyc;
        int  got_cyc;
        int  hits;
        bit  ok;

        vecs[0] = '{1'b0, 17'h08000, 8'h41, 8'h00, 32'h0080_0041, 8'h00, 50, 3, 1'b0};
        vecs[1] = '{1'b1, 17'h1E80E, 8'h00, 8'hA5, 32'h81E8_0E00, 8'hA5, 50, 35, 1'b0};
        vecs[2] = '{1'b0, 17'h1FFFF, 8'hFF, 8'h00, 32'h01FF_FFFF, 8'h00, 10, 3, 1'b1};
        vecs[3] = '{1'b1, 17'h00000, 8'h77, 8'h5A, 32'h8000_0000, 8'h5A, 0, 36, 1'b0};
        vecs[4] = '{1'b1, 17'h10001, 8'hC3, 8'h81, 32'h8100_0100, 8'h81, 7, 35, 1'b0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_cs", 32'(cs_n), 32'd1);
        check("rst_tx", 32'(tx), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
            repeat (3) @(posedge clk);
            #1;
        end

        // Reset in the middle of a frame while SCLK is high.
        base = win_count;
        issue(1'b0, 17'h12345, 8'h99);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (sclk) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_frame_sclk_high", 32'(ok), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_cs", 32'(cs_n), 32'd1);
        check("async_rst_sclk", 32'(sclk), 32'd0);
        check("async_rst_rsp_data", 32'(rsp_data), 32'd0);
        @(posedge clk);
        #1;
        check("rst_edge_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_edge_cs", 32'(cs_n), 32'd1);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid || !cs_n) hits++;
        end
        check("no_rsp_after_reset", 32'(hits), 32'd0);

        // Stale ready: low across the start, high 3 cycles after cs rises, low again 20 later.
        ready_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        base = win_count;
        issue(1'b0, 17'h00ABC, 8'h3C);
        wait_win(base, ok);
        check("stale_frame_end_seen", 32'(ok), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        ready_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        ready_n = 1'b0;
        rdy_cyc = cyc;
        wait_rsp(200, ok, got_cyc);
        check("stale_rsp_seen", 32'(ok), 32'd1);
        check("stale_latency", 32'(got_cyc - rdy_cyc), 32'd3);
        check("stale_frame_mosi", win_data[base % 16], 32'h000A_BC3C);
        ready_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

`ifdef SPI_INITIATOR_TIMEOUT_EN
        base = win_count;
        issue(1'b0, 17'h00010, 8'h55);
        wait_win(base, ok);
        check("tmo_frame_end_seen", 32'(ok), 32'd1);
        rdy_cyc = cyc;
        wait_rsp(300, ok, got_cyc);
        check("tmo_rsp_seen", 32'(ok), 32'd1);
        check("tmo_latency", 32'(got_cyc - rdy_cyc), 32'd103);
        check("tmo_flag", 32'(rsp_timeout), 32'd1);
        check("tmo_data", 32'(rsp_data), 32'd0);
        @(posedge clk);
        #1;
        check("tmo_ready_after", 32'(cmd_ready), 32'd1);
`endif

        check("sclk_period_min", 32'(per_min), 32'd4);
        check("sclk_period_max", 32'(per_max), 32'd4);
        check("first_bit_setup_min", 32'(setup_min), 32'd2);
        check("first_bit_setup_max", 32'(setup_max), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1);
    end

endmodule
